// File: rtl/write_back_arbiter.sv
// Arbitrates the single register-file write port between the in-order pipeline and queued mul/div results.
// Latency: a granted source appears on rf_* one cycle later; an MDU result waits at least one cycle in the FIFO.
// Backpressure: mdu_ready=0 when the FIFO is full; pipe_stall=1 for exactly one cycle whenever a drain is forced.
// Ports: clk/rst_n; pipe_valid/pipe_rd/pipe_data in, pipe_stall out; mdu_valid/mdu_rd/mdu_data in,
//        mdu_ready out; rf_we/rf_waddr/rf_wdata registered write port; fifo_count queued entries.
module write_back_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pipe_valid,
    input  logic [ADDR_W-1:0]          pipe_rd,
    input  logic [DATA_W-1:0]          pipe_data,
    output logic                       pipe_stall,
    input  logic                       mdu_valid,
    input  logic [ADDR_W-1:0]          mdu_rd,
    input  logic [DATA_W-1:0]          mdu_data,
    output logic                       mdu_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {PIPE_PRI, MDU_FORCE} state_t;

    state_t              state_q, state_d;
    logic [7:0]          wait_q, wait_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

    // Entry storage carries no reset: validity is tracked by count/pointers alone.
    logic [ADDR_W-1:0]   rd_mem_q   [DEPTH];
    logic [DATA_W-1:0]   data_mem_q [DEPTH];

    logic fifo_empty, fifo_full, push, grant_pipe, grant_fifo, wait_inc;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        // Ready looks only at occupancy, so a full FIFO refuses even while popping.
        push       = mdu_valid && !fifo_full;
        grant_pipe = (state_q == PIPE_PRI) && pipe_valid;
        grant_fifo = !fifo_empty && ((state_q == MDU_FORCE) || !pipe_valid);
        // Age counts only cycles in which a queued head was passed over.
        wait_inc   = (state_q == PIPE_PRI) && !fifo_empty && !grant_fifo;

        wait_d   = wait_inc ? wait_q + 8'd1 : 8'd0;
        state_d  = PIPE_PRI;
        if (wait_inc && ((wait_d >= 8'(MAX_WAIT)) || fifo_full))
            state_d = MDU_FORCE;

        wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + (grant_fifo ? PTR_W'(1) : PTR_W'(0));
        count_d  = count_q + CNT_W'(push) - CNT_W'(grant_fifo);

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_pipe) begin
            rf_we_d    = (pipe_rd != '0);
            rf_waddr_d = pipe_rd;
            rf_wdata_d = pipe_data;
        end else if (grant_fifo) begin
            rf_we_d    = (rd_mem_q[rd_ptr_q] != '0);
            rf_waddr_d = rd_mem_q[rd_ptr_q];
            rf_wdata_d = data_mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PIPE_PRI;
            wait_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= mdu_rd;
            data_mem_q[wr_ptr_q] <= mdu_data;
        end
    end

    assign pipe_stall = (state_q == MDU_FORCE);
    assign mdu_ready  = !fifo_full;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign fifo_count = count_q;
endmodule
